quad_step_decoder: RTL and testbench
====================================

# quad_step_decoder

Decodes a two-channel quadrature encoder (A/B) into the single-cycle `enable` / `up_down` command pair consumed by the 8-bit up/down counter directly downstream. The block performs these steps:
- Synchronizes the asynchronous A/B pins.
- Rejects glitches with a per-channel stability filter.
- Tracks the Gray-code phase and emits one count command per legal phase step.
- Flags illegal double-bit transitions with a sticky error and a saturating error counter.

## Interface
- SYNC_STAGES, 2: synchronizer flops per channel; legal range 2..4.
- FILTER_LEN, 3: consecutive cycles a synchronized level must differ from the filtered level before it is accepted; legal range 1..15.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  reset, synchronous, active-high.
- quad_a  input  1  encoder channel A; asynchronous to clk.
- quad_b  input  1  encoder channel B; asynchronous to clk.
- clear_err  input  1  synchronous clear of `err` and `err_cnt`.
- enable  output  1  one-cycle count-step pulse to the counter.
- up_down  output  1  direction qualifier for `enable`: 1 = up, 0 = down.
- err  output  1  sticky illegal-transition flag.
- err_cnt  output  8  illegal-transition count; saturates at 255.

## Operation
- Synchronizer: each channel passes through SYNC_STAGES flops. All flops reset to 0.
- Filter, per channel: holds a filtered level `f` (reset 0) and a counter `fc` (reset 0).
  - When the synchronized value differs from `f`, `fc` increments.
  - When `fc` reaches FILTER_LEN-1 and the values still differ, `f` takes the synchronized value on that edge and `fc` returns to 0.
  - When the synchronized value equals `f`, `fc` clears to 0.
- Decoder FSM states:
  - INIT (reset state): waits for both filters to be idle, with `fc`=0 and `f` equal to the synchronized value, for one cycle. It then loads the previous-phase register `p` from `{f_a,f_b}` and moves to RUN. No `enable` or `err` is produced in INIT.
  - RUN: each cycle compares `{f_a,f_b}` with `p`, then `p` updates to `{f_a,f_b}`.
- RUN decode rules:
  - Forward sequence 00→10→11→01→00 (A leads): `enable`=1 next cycle with `up_down`=1.
  - Reverse sequence 00→01→11→10→00: `enable`=1 next cycle with `up_down`=0.
  - No change: `enable`=0, and `up_down` holds its last value.
  - Both bits changed in the same cycle (00↔11, 10↔01): illegal. `enable`=0, `up_down` holds, `err`←1, `err_cnt`←min(err_cnt+1,255). `p` still updates to the new phase.
- clear_err: `err`←0 and `err_cnt`←0 next cycle. If an illegal event occurs in the same cycle, the event wins: `err`=1 and `err_cnt`=1.
- Reset values: `enable`=0, `up_down`=1, `err`=0, `err_cnt`=0, FSM=INIT.
- Reset mid-operation: all state returns to reset values on the next edge. Any in-progress filter count is discarded, and no `enable` pulse is emitted while `reset` is high.

## Timing
- All outputs are registered. `enable` is never high for two consecutive cycles.
- Latency: a level change stable on a pin before clk edge k produces `enable` high in the cycle following edge k+SYNC_STAGES+FILTER_LEN. With defaults, that is 6 cycles after the first sampling edge.
- `up_down` is valid in the same cycle as `enable`. The downstream counter samples both on the next rising edge.
- Minimum legal phase spacing: FILTER_LEN+1 cycles per channel edge. Faster inputs may be filtered out or may merge into an illegal double change. Both outcomes are defined by the rules above.
- Pulses shorter than FILTER_LEN cycles after synchronization never change `f`.
- After reset deassertion, INIT takes at least SYNC_STAGES+1 cycles before RUN. Inputs sitting at 11 after reset do not produce an error.

## Test plan
- Reset with pins at A=1,B=1, hold 20 cycles → `enable` never pulses, `err`=0, FSM reaches RUN. Then drive forward step 11→01 → exactly one `enable` with `up_down`=0? No: 11→01 is forward, so exactly one `enable` with `up_down`=1, 6 cycles after the pin change.
- Forward full cycle 00→10→11→01→00, spaced 8 cycles apart → 4 `enable` pulses, all with `up_down`=1; downstream count increments from 0 to 4. Then the reverse cycle → 4 pulses with `up_down`=0, and the count returns to 0.
- 2-cycle glitch on A (0→1→0) → no `enable`, `err`=0, `f_a` stays 0. 3-cycle pulse → one up pulse followed by one down pulse.
- A and B toggled in the same cycle (00→11) → no `enable`, `err`=1, `err_cnt`=1. Repeat 300 times → `err_cnt`=255. `clear_err` pulse → `err`=0, `err_cnt`=0. `clear_err` coincident with an illegal event → `err`=1, `err_cnt`=1.
- `reset` asserted 2 cycles after an A edge, before the filter accepts it → no `enable` pulse, all outputs at reset values. After release, FSM re-enters INIT and resyncs to the current pin levels without error.

Source files
------------

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronizes and de-glitches the A/B pins,
// tracks the Gray-code phase and issues one-cycle enable/up_down count
// commands to the downstream 8-bit counter. Double-bit phase jumps are
// reported through a sticky flag and a saturating counter.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quad_a,
  input  logic       quad_b,
  input  logic       clear_err,
  output logic       enable,
  output logic       up_down,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] FC_MAX   = 4'(FILTER_LEN - 1);
  localparam logic [2:0] INIT_LEN = 3'(SYNC_STAGES);

  typedef enum logic {INIT, RUN} state_t;

  // Channel index 1 = A, 0 = B, so {x[1],x[0]} reads as the {A,B} phase.
  logic [1:0][SYNC_STAGES-1:0] sync;
  logic [1:0]                  s;
  logic [1:0]                  f;
  logic [1:0][3:0]             fc;
  logic [1:0]                  p;
  logic [2:0]                  init_cnt;
  state_t                      state, state_nxt;
  logic                        load_p;
  logic                        idle, init_done;
  logic [1:0]                  diff;
  logic                        step, illegal, dir, defer;

  assign s[1] = sync[1][SYNC_STAGES-1];
  assign s[0] = sync[0][SYNC_STAGES-1];

  // Synchronizer chains, one per channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync[1] <= {sync[1][SYNC_STAGES-2:0], quad_a};
      sync[0] <= {sync[0][SYNC_STAGES-2:0], quad_b};
    end
  end

  // Stability filter: a new level must persist FILTER_LEN samples to be taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      f  <= '0;
      fc <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s[i] != f[i]) begin
          if (fc[i] == FC_MAX) begin
            f[i]  <= s[i];
            fc[i] <= '0;
          end else begin
            fc[i] <= fc[i] + 4'd1;
          end
        end else begin
          fc[i] <= '0;
        end
      end
    end
  end

  assign idle      = (fc == '0) && (f == s);
  assign init_done = (init_cnt == INIT_LEN);

  // INIT dwell counter: guarantees the sync chain holds real pin levels
  // before idle is trusted, so pins parked at 11 never look like a jump.
  always_ff @(posedge clk) begin
    if (reset)                         init_cnt <= '0;
    else if (state == INIT && !init_done) init_cnt <= init_cnt + 3'd1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  // FSM next state: leave INIT once both filters have settled.
  always_comb begin
    state_nxt = state;
    load_p    = 1'b0;
    case (state)
      INIT: if (init_done && idle) begin
        state_nxt = RUN;
        load_p    = 1'b1;
      end
      RUN:  state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Phase step classification. For a single-bit change, forward (A leads)
  // is exactly prev_B xor new_A.
  assign diff    = f ^ p;
  assign step    = (state == RUN) && (diff == 2'b01 || diff == 2'b10);
  assign illegal = (state == RUN) && (diff == 2'b11);
  assign dir     = p[0] ^ f[1];
  // A step arriving right behind a pulse is held for one cycle (p not
  // advanced) so enable never goes high two cycles in a row.
  assign defer   = step && enable;

  // Previous-phase register.
  always_ff @(posedge clk) begin
    if (reset)                              p <= '0;
    else if (load_p || (state == RUN && !defer)) p <= f;
  end

  // Count command outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable  <= 1'b0;
      up_down <= 1'b1;
    end else begin
      enable <= step && !enable;
      if (step && !enable) up_down <= dir;
    end
  end

  // Error reporting; an illegal event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (illegal) begin
      err <= 1'b1;
      if (clear_err)              err_cnt <= 8'd1;
      else if (err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
    end else if (clear_err) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: expected count commands are queued when a
// phase step is driven and popped as enable pulses appear.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       quad_a = 1'b0, quad_b = 1'b0, clear_err = 1'b0;
  logic       enable, up_down, err;
  logic [7:0] err_cnt;

  int   checks = 0, errors = 0;
  bit   exp_q[$];
  bit   exp_ud;
  logic prev_en = 1'b0;
  logic [7:0] ds_cnt;

  quad_step_decoder #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b),
    .clear_err(clear_err), .enable(enable), .up_down(up_down),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Downstream 8-bit up/down counter.
  always @(posedge clk) begin
    if (reset)       ds_cnt <= 8'd0;
    else if (enable) ds_cnt <= up_down ? ds_cnt + 8'd1 : ds_cnt - 8'd1;
  end

  // Scoreboard: every enable pulse must match the next queued direction.
  always @(negedge clk) begin
    if (enable === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_enable up_down=%0b none expected t=%0t", up_down, $time);
      end else begin
        exp_ud = exp_q.pop_front();
        if (up_down !== exp_ud) begin
          errors++;
          $display("FAIL pulse_dir got=%0b exp=%0b t=%0t", up_down, exp_ud, $time);
        end
      end
      checks++;
      if (prev_en === 1'b1) begin
        errors++;
        $display("FAIL back_to_back_enable got=1 exp=0 t=%0t", $time);
      end
    end
    prev_en = enable;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b1; quad_a = 1'b1; quad_b = 1'b1;
    step(3);
    checks++;
    if ({enable, up_down, err, err_cnt} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values got=%b_%b_%b_%h exp=0_1_0_00", enable, up_down, err, err_cnt);
    end
    reset = 1'b0;
    step(20);
    checks++;
    if (err !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL init_at_11 got err=%b cnt=%0d exp err=0 cnt=0", err, err_cnt);
    end
    // 11 -> 01 is a forward step; measure pin-to-enable latency.
    exp_q.push_back(1'b1);
    quad_a = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      step();
      if (enable === 1'b1) lat = i;
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL first_step_latency got=%0d exp=6", lat);
    end
    step(8);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL first_step_missing got=%0d pending exp=0", exp_q.size());
    end
  endtask

  task automatic test_forward_reverse();
    logic [1:0] fwd [4];
    logic [1:0] rev [4];
    logic [7:0] base;
    fwd = '{2'b10, 2'b11, 2'b01, 2'b00};
    rev = '{2'b01, 2'b11, 2'b10, 2'b00};
    exp_q.push_back(1'b1);            // 01 -> 00
    quad_a = 1'b0; quad_b = 1'b0;
    step(8);
    base = ds_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(1'b1);
      {quad_a, quad_b} = fwd[i];
      step(8);
    end
    checks++;
    if (ds_cnt !== base + 8'd4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL forward_count got=%0d pending=%0d exp=%0d pending=0", ds_cnt, exp_q.size(), base + 8'd4);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(1'b0);
      {quad_a, quad_b} = rev[i];
      step(8);
    end
    checks++;
    if (ds_cnt !== base || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reverse_count got=%0d pending=%0d exp=%0d pending=0", ds_cnt, exp_q.size(), base);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL legal_steps_err got=%b exp=0", err);
    end
  endtask

  task automatic test_glitch();
    quad_a = 1'b1; step(2);
    quad_a = 1'b0; step(15);
    checks++;
    if (err !== 1'b0 || up_down !== 1'b0) begin
      errors++;
      $display("FAIL glitch_2cyc got err=%b up_down=%b exp err=0 up_down=0", err, up_down);
    end
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    quad_a = 1'b1; step(3);
    quad_a = 1'b0; step(15);
    checks++;
    if (exp_q.size() != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL pulse_3cyc got pending=%0d err=%b exp pending=0 err=0", exp_q.size(), err);
    end
  endtask

  task automatic test_illegal();
    quad_a = 1'b1; quad_b = 1'b1;
    step(10);
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL illegal_once got err=%b cnt=%0d exp err=1 cnt=1", err, err_cnt);
    end
    for (int i = 0; i < 253; i++) begin
      {quad_a, quad_b} = {~quad_a, ~quad_b};
      step(6);
    end
    checks++;
    if (err_cnt !== 8'd254) begin
      errors++;
      $display("FAIL illegal_254 got=%0d exp=254", err_cnt);
    end
    for (int i = 0; i < 46; i++) begin
      {quad_a, quad_b} = {~quad_a, ~quad_b};
      step(6);
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL illegal_saturate got=%0d exp=255", err_cnt);
    end
    clear_err = 1'b1; step();
    clear_err = 1'b0;
    checks++;
    if (err !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clear_err got err=%b cnt=%0d exp err=0 cnt=0", err, err_cnt);
    end
    // Illegal 00 -> 11 lands on the 6th edge after the pin change.
    quad_a = 1'b1; quad_b = 1'b1;
    step(5);
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL pre_coincident got=%0d exp=0", err_cnt);
    end
    clear_err = 1'b1; step();
    clear_err = 1'b0;
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clear_vs_event got err=%b cnt=%0d exp err=1 cnt=1", err, err_cnt);
    end
    step(10);
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL err_sticky got err=%b cnt=%0d exp err=1 cnt=1", err, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    quad_a = 1'b0;                     // 11 -> 01, cut off by reset
    step(2);
    reset = 1'b1;
    step(2);
    checks++;
    if ({enable, up_down, err, err_cnt} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset_values got=%b_%b_%b_%h exp=0_1_0_00", enable, up_down, err, err_cnt);
    end
    reset = 1'b0;
    step(20);
    checks++;
    if (err !== 1'b0 || err_cnt !== 8'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL resync got err=%b cnt=%0d pending=%0d exp 0 0 0", err, err_cnt, exp_q.size());
    end
    exp_q.push_back(1'b1);             // 01 -> 00 after resync
    quad_b = 1'b0;
    step(10);
    checks++;
    if (exp_q.size() != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL post_resync_step got pending=%0d err=%b exp pending=0 err=0", exp_q.size(), err);
    end
  endtask

  initial begin
    test_reset();
    test_forward_reverse();
    test_glitch();
    test_illegal();
    test_reset_mid();
    step(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
